// File: rtl/bcd_timer_display.sv
// BCD MM:SS timer advanced by rising edges of clk_div, driving a 4-digit multiplexed active-low 7-segment display.
// Latency: a count is visible 1 cycle after the tick; an/seg are registered 1 cycle after scan_idx and the digits.
// No backpressure: ticks arriving while run=0 or clr=1 are dropped. Optional macro LEADING_ZERO_BLANK_EN blanks leading minute zeros.
module bcd_timer_display #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_div,
    input  logic       run,
    input  logic       clr,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       carry,
    output logic [3:0] an,
    output logic [6:0] seg
);

    // Last value of the 20-bit scan counter before the display moves to the next digit.
    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    // Segment pattern that turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // clk_div sampled as data. The tick is its 0->1 transition in the clk_in domain.
    logic        div_q,      div_d;
    logic        tick;

    // Timer digits and the wrap pulse.
    logic [3:0]  sec_ones_q, sec_ones_d;
    logic [3:0]  sec_tens_q, sec_tens_d;
    logic [3:0]  min_ones_q, min_ones_d;
    logic [3:0]  min_tens_q, min_tens_d;
    logic        carry_q,    carry_d;

    // Display multiplexer state and its registered outputs.
    logic [19:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  scan_idx_q, scan_idx_d;
    logic [3:0]  an_q,       an_d;
    logic [6:0]  seg_q,      seg_d;
    logic        scan_last;
    logic [3:0]  cur_digit;
    logic        cur_blank;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit. Codes 10..15 never occur
    // in normal operation and are shown blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Edge detect. div_d always follows clk_div, so an edge seen while the timer is
    // held or cleared is consumed and cannot fire again later.
    always_comb begin
        div_d = clk_div;
        tick  = clk_div & ~div_q;
    end

    // BCD count with ripple carry through SS and MM. clr wins over a same-cycle tick.
    // carry is high only in the cycle in which the timer wraps to 00:00.
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        carry_d    = 1'b0;
        if (clr) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else if (tick && run) begin
            if (sec_ones_q != 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q != 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        if (min_tens_q != 4'd5) begin
                            min_tens_d = min_tens_q + 4'd1;
                        end else begin
                            min_tens_d = 4'd0;
                            carry_d    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Scan timing. Each digit is selected for SCAN_DIV cycles, independent of run and clr.
    always_comb begin
        scan_last = (scan_cnt_q == SCAN_LAST);
        if (scan_last) begin
            scan_cnt_d = 20'd0;
            scan_idx_d = scan_idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 20'd1;
            scan_idx_d = scan_idx_q;
        end
    end

    // Digit select and segment decode for the currently scanned position.
    always_comb begin
        case (scan_idx_q)
            2'd0:    cur_digit = sec_ones_q;
            2'd1:    cur_digit = sec_tens_q;
            2'd2:    cur_digit = min_ones_q;
            default: cur_digit = min_tens_q;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A zero tens-of-minutes is suppressed, and the ones-of-minutes digit too when
        // the whole minute field is zero. Seconds always show.
        cur_blank = ((scan_idx_q == 2'd3) && (min_tens_q == 4'd0)) ||
                    ((scan_idx_q == 2'd2) && (min_tens_q == 4'd0) && (min_ones_q == 4'd0));
`else
        cur_blank = 1'b0;
`endif
        an_d  = ~(4'b0001 << scan_idx_q);
        seg_d = cur_blank ? SEG_BLANK : seg_decode(cur_digit);
    end

    // All state. Reset is asynchronous and blanks the display immediately.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_q      <= 1'b0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            carry_q    <= 1'b0;
            scan_cnt_q <= 20'd0;
            scan_idx_q <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_BLANK;
        end else begin
            div_q      <= div_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            carry_q    <= carry_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        sec_ones = sec_ones_q;
        sec_tens = sec_tens_q;
        min_ones = min_ones_q;
        min_tens = min_tens_q;
        carry    = carry_q;
        an       = an_q;
        seg      = seg_q;
    end

endmodule
